mem_wr_arbiter: RTL and testbench

//   Round-robin arbiter sharing the single write port of the dual-port FIFO memory among

---
 rtl/mem_wr_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_wr_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO memory write port among NREQ producers, bursts bounded by MAX_BURST.
// Optional per-requester accepted-beat counters on beat_cnt when ARB_STATS_EN is defined.
module mem_wr_arbiter #(
    parameter int DATAWIDTH = 8,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4,
    parameter int IDW       = $clog2(NREQ),
    parameter int CNTW      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ-1:0]           req_last,
    input  logic [NREQ*DATAWIDTH-1:0] req_data,
    output logic [NREQ-1:0]           req_ready,
    input  logic                      full,
    output logic                      wr,
    output logic [DATAWIDTH-1:0]      Wdata,
    output logic [IDW-1:0]            grant_id,
    output logic                      busy
`ifdef ARB_STATS_EN
    ,
    output logic [NREQ*CNTW-1:0]      beat_cnt
`endif
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BURST_END = BW'(MAX_BURST - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    if (NREQ < 2 || MAX_BURST < 1 || CNTW < 1) begin : g_bad_params
        $error("mem_wr_arbiter: illegal parameter values");
    end

    logic [0:0]           state;
    logic [IDW-1:0]       last_id;
    logic [IDW-1:0]       next_id;
    logic                 any_valid;
    logic [BW-1:0]        burst;
    logic                 sel_valid;
    logic                 sel_last;
    logic [DATAWIDTH-1:0] sel_data;

    // Scan downward over offsets so the smallest offset from last_id+1 wins.
    always_comb begin
        int             idx;
        logic [IDW-1:0] cand;
        idx       = 0;
        cand      = '0;
        next_id   = '0;
        any_valid = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            idx  = (int'(last_id) + k) % NREQ;
            cand = IDW'(idx);
            if (req_valid[cand]) begin
                next_id   = cand;
                any_valid = 1'b1;
            end
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id == IDW'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[i*DATAWIDTH +: DATAWIDTH];
            end
        end
    end

    always_comb begin
        busy      = (state == S_GRANT);
        wr        = busy & sel_valid & ~full;
        Wdata     = busy ? sel_data : '0;
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = busy && !full && (grant_id == IDW'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            last_id  <= IDW'(NREQ - 1);
            burst    <= '0;
            grant_id <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_valid) begin
                        grant_id <= next_id;
                        last_id  <= next_id;
                        burst    <= '0;
                        state    <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    // While full stalls, burst stays frozen; only a dropped valid releases.
                    if (!sel_valid) begin
                        state <= S_IDLE;
                    end else if (wr) begin
                        burst <= burst + BW'(1);
                        if (sel_last || burst == BURST_END) begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (wr) begin
            for (int i = 0; i < NREQ; i++) begin
                if (grant_id == IDW'(i)) begin
                    beat_cnt[i*CNTW +: CNTW] <= beat_cnt[i*CNTW +: CNTW] + CNTW'(1);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_wr_arbiter.sv
// Bench for mem_wr_arbiter: requester models feed beats, a scoreboard queue holds the expected
// (grant_id, Wdata) sequence and a negedge monitor checks every write.
module tb_mem_wr_arbiter;

    localparam int DW = 8;
    localparam int N  = 4;
    localparam int MB = 4;
`ifdef ARB_STATS_EN
    localparam int CW = 4;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_last;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]  req_ready;
    logic          full;
    logic          wr;
    logic [DW-1:0] Wdata;
    logic [1:0]    grant_id;
    logic          busy;
`ifdef ARB_STATS_EN
    logic [N*CW-1:0] beat_cnt;
`endif

    mem_wr_arbiter #(
        .DATAWIDTH(DW),
        .NREQ(N),
        .MAX_BURST(MB)
`ifdef ARB_STATS_EN
        ,
        .CNTW(CW)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_last(req_last),
        .req_data(req_data),
        .req_ready(req_ready),
        .full(full),
        .wr(wr),
        .Wdata(Wdata),
        .grant_id(grant_id),
        .busy(busy)
`ifdef ARB_STATS_EN
        ,
        .beat_cnt(beat_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    // Requester i: rem beats left, sent = index of the current beat, last flagged on beat last_at.
    int rem[N]     = '{default: 0};
    int sent[N]    = '{default: 0};
    int last_at[N] = '{default: -1};
    logic [N-1:0] acc = '0;
    logic [9:0]   sb[$];

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] e);
        total++;
        if (act === e) passed++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, e, $time);
    endfunction

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < N; i++) s += rem[i];
        return s;
    endfunction

    always_comb begin
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = (rem[i] > 0);
            req_last[i]           = (sent[i] == last_at[i]);
            req_data[i*DW +: DW]  = DW'((i << 4) | (sent[i] & 15));
        end
    end

    always @(negedge clk) acc = req_valid & req_ready;

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                rem[i]  = rem[i] - 1;
                sent[i] = sent[i] + 1;
            end
        end
        acc = '0;
    end

    always @(negedge clk) begin
        logic [9:0] e;
        if (wr) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_write: got id=%0d data=%h, expected no write", grant_id, Wdata);
            end else begin
                e = sb.pop_front();
                chk("beat_id_data", 32'({grant_id, Wdata}), 32'(e));
            end
        end
        if (full) chk("no_wr_when_full", 32'(wr), 32'd0);
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic load(int i, int n, int la, int st);
        rem[i]     = n;
        sent[i]    = st;
        last_at[i] = la;
    endtask

    task automatic expect_beats(int i, int st, int n);
        for (int k = 0; k < n; k++) sb.push_back({2'(i), DW'((i << 4) | ((st + k) & 15))});
    endtask

    task automatic wait_idle(int maxc);
        int c = 0;
        while ((busy || sb.size() != 0 || pending() != 0) && c < maxc) begin
            @(negedge clk);
            c++;
        end
        chk("wait_idle_in_budget", 32'(c < maxc), 32'd1);
        cyc();
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_wr"}, 32'(wr), 32'd0);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_wdata"}, 32'(Wdata), 32'd0);
        chk({tag, "_grant_id"}, 32'(grant_id), 32'd0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, got t=%0t expected completion", $time);
        $fatal(1);
    end

    initial begin
        int nwr, nidle;
        rst  = 1'b1;
        full = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        cyc();
        cyc();
        rst = 1'b0;

        // Test 1: all four requesting continuously -> 0,1,2,3,0 with 4 beats each
        load(0, 8, -1, 0);
        load(1, 4, -1, 0);
        load(2, 4, -1, 0);
        load(3, 4, -1, 0);
        expect_beats(0, 0, 4);
        expect_beats(1, 0, 4);
        expect_beats(2, 0, 4);
        expect_beats(3, 0, 4);
        expect_beats(0, 4, 4);
        nwr = 0;
        nidle = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (wr) nwr++;
            if (!busy) nidle++;
        end
        chk("rr_beats_in_window", 32'(nwr), 32'd20);
        chk("rr_bubbles_in_window", 32'(nidle), 32'd5);
        wait_idle(40);

        // Test 2: req 2 flags last on its second beat; third beat needs a fresh grant
        load(2, 3, 1, 0);
        expect_beats(2, 0, 3);
        @(negedge clk);
        chk("t2_bubble", 32'(busy), 32'd0);
        @(negedge clk);
        chk("t2_beat1_wr", 32'(wr), 32'd1);
        @(negedge clk);
        chk("t2_beat2_wr", 32'(wr), 32'd1);
        @(negedge clk);
        chk("t2_release_busy", 32'(busy), 32'd0);
        chk("t2_release_wr", 32'(wr), 32'd0);
        wait_idle(20);

        // Test 3: req 1 stalled by full for 5 cycles after two beats
        load(1, 5, -1, 0);
        expect_beats(1, 0, 5);
        cyc();
        cyc();
        cyc();
        full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t3_stall_wr", 32'(wr), 32'd0);
            chk("t3_stall_ready", 32'(req_ready), 32'd0);
            chk("t3_stall_grant", 32'(grant_id), 32'd1);
            chk("t3_stall_busy", 32'(busy), 32'd1);
            cyc();
        end
        full = 1'b0;
        @(negedge clk);
        chk("t3_resume_beat3", 32'(wr), 32'd1);
        @(negedge clk);
        chk("t3_resume_beat4", 32'(wr), 32'd1);
        @(negedge clk);
        chk("t3_burst_release", 32'(busy), 32'd0);
        wait_idle(20);

        // Test 4: req 3 alone, valid drops after one beat, then re-raised
        load(3, 1, -1, 0);
        expect_beats(3, 0, 1);
        @(negedge clk);
        @(negedge clk);
        chk("t4_beat_wr", 32'(wr), 32'd1);
        @(negedge clk);
        chk("t4_drop_wr", 32'(wr), 32'd0);
        chk("t4_drop_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("t4_released", 32'(busy), 32'd0);
        cyc();
        load(3, 1, -1, 1);
        expect_beats(3, 1, 1);
        wait_idle(20);

        // Test 5: reset during beat 2 of a burst to req 1
        load(1, 4, -1, 0);
        expect_beats(1, 0, 1);
        cyc();
        cyc();
        rst = 1'b1;
        #1;
        check_reset_outputs("midburst_rst");
        load(0, 1, -1, 0);
        load(3, 1, -1, 2);
        cyc();
        rst = 1'b0;
        expect_beats(0, 0, 1);
        expect_beats(1, 1, 3);
        expect_beats(3, 2, 1);
        wait_idle(60);

`ifdef ARB_STATS_EN
        // Test 6: 17 beats from req 0 wrap a 4-bit counter to 1
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        load(0, 17, -1, 0);
        expect_beats(0, 0, 17);
        wait_idle(100);
        chk("stats_cnt0", 32'(beat_cnt[0*CW +: CW]), 32'd1);
        chk("stats_cnt1", 32'(beat_cnt[1*CW +: CW]), 32'd0);
        chk("stats_cnt2", 32'(beat_cnt[2*CW +: CW]), 32'd0);
        chk("stats_cnt3", 32'(beat_cnt[3*CW +: CW]), 32'd0);
`endif

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
